// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/writeback sequencer owning PC and IR.
// Define CPU_CTRL_HALT_DETECT_EN to make an all-zero IR halt the core until reset.
module cpu_control_fsm #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     ir_o,
    input  logic            dec_is_branch_i,
    input  logic            dec_is_jump_i,
    input  logic            dec_is_imm_i,
    input  logic [31:0]     dec_imm_i,
    input  logic            alu_zero_i,
    output logic [PC_W-1:0] pc_o,
    output logic            alu_en_o,
    output logic            alu_src_imm_o,
    output logic            rf_we_o,
    output logic            retired_o,
    output logic [2:0]      state_o,
    output logic            halted_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic            req_pending_q;
    logic            is_branch_q;
    logic            is_jump_q;
    logic [PC_W-1:0] imm_q;
    logic            taken_q;
    logic            alu_en_q;
    logic            alu_src_imm_q;
    logic            rf_we_q;
    logic            retired_q;
`ifdef CPU_CTRL_HALT_DETECT_EN
    logic            halted_q;
`endif

    logic            unused_imm;
    logic            redirect;

    // Only the low PC_W bits of the offset can affect a modulo-2^PC_W PC.
    assign unused_imm = ^dec_imm_i[31:PC_W];
    assign redirect   = is_jump_q | (is_branch_q & taken_q);

    assign imem_req_o    = (state_q == S_FETCH) & (run_i | req_pending_q) & ~rst_i;
    assign imem_addr_o   = pc_q;
    assign ir_o          = ir_q;
    assign pc_o          = pc_q;
    assign alu_en_o      = alu_en_q;
    assign alu_src_imm_o = alu_src_imm_q;
    assign rf_we_o       = rf_we_q;
    assign retired_o     = retired_q;
    assign state_o       = state_q;
`ifdef CPU_CTRL_HALT_DETECT_EN
    assign halted_o      = halted_q;
`else
    assign halted_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            req_pending_q <= 1'b0;
            is_branch_q   <= 1'b0;
            is_jump_q     <= 1'b0;
            imm_q         <= '0;
            taken_q       <= 1'b0;
            alu_en_q      <= 1'b0;
            alu_src_imm_q <= 1'b0;
            rf_we_q       <= 1'b0;
            retired_q     <= 1'b0;
`ifdef CPU_CTRL_HALT_DETECT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; each state re-arms the next one.
            alu_en_q      <= 1'b0;
            alu_src_imm_q <= 1'b0;
            rf_we_q       <= 1'b0;
            retired_q     <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (imem_req_o) begin
                        if (imem_ready_i) begin
                            ir_q          <= imem_rdata_i;
                            req_pending_q <= 1'b0;
                            state_q       <= S_DECODE;
                        end else begin
                            req_pending_q <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    is_branch_q   <= dec_is_branch_i;
                    is_jump_q     <= dec_is_jump_i;
                    imm_q         <= dec_imm_i[PC_W-1:0];
                    alu_en_q      <= 1'b1;
                    alu_src_imm_q <= dec_is_imm_i;
                    state_q       <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    taken_q   <= alu_zero_i;
                    rf_we_q   <= ~(is_branch_q | is_jump_q);
                    retired_q <= 1'b1;
                    state_q   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
`ifdef CPU_CTRL_HALT_DETECT_EN
                    if (ir_q == 32'd0) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        pc_q    <= redirect ? pc_q + imm_q : pc_q + PC_W'(1);
                        state_q <= S_FETCH;
                    end
`else
                    pc_q    <= redirect ? pc_q + imm_q : pc_q + PC_W'(1);
                    state_q <= S_FETCH;
`endif
                end
                S_HALT: begin
`ifdef CPU_CTRL_HALT_DETECT_EN
                    halted_q <= 1'b1;
`else
                    state_q <= S_FETCH;
`endif
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed program with queue scoreboard for retire and execute events.
// Covers zero-wait and stalled fetch, branches, wrap, reset aborts and the IR=0 case.
module tb_cpu_control_fsm;

    typedef struct {
        logic [31:0] ir;
        logic        rf_we;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        dec_is_branch;
    logic        dec_is_jump;
    logic        dec_is_imm;
    logic [31:0] dec_imm;
    logic        alu_zero = 1'b0;
    logic [15:0] pc;
    logic        alu_en;
    logic        alu_src_imm;
    logic        rf_we;
    logic        retired;
    logic [2:0]  state;
    logic        halted;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int wait_cycles = 0;
    int wcnt = 0;
    logic force_ready = 1'b0;

    logic [31:0] mem [logic [15:0]];
    exp_t sb_q[$];
    logic src_q[$];
    logic zq[$];

    cpu_control_fsm dut (
        .clk_i(clk), .rst_i(rst), .run_i(run),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
        .ir_o(ir),
        .dec_is_branch_i(dec_is_branch), .dec_is_jump_i(dec_is_jump),
        .dec_is_imm_i(dec_is_imm), .dec_imm_i(dec_imm),
        .alu_zero_i(alu_zero), .pc_o(pc),
        .alu_en_o(alu_en), .alu_src_imm_o(alu_src_imm),
        .rf_we_o(rf_we), .retired_o(retired),
        .state_o(state), .halted_o(halted)
    );

    always #5 clk = ~clk;

    // Instruction decoder model feeding the sequencer.
    always_comb begin
        dec_is_jump   = (ir[31:29] == 3'b000);
        dec_is_branch = (ir[31:29] == 3'b001);
        dec_is_imm    = (ir[31:30] == 2'b11);
        dec_imm       = {{18{ir[13]}}, ir[13:0]};
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_rd(logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'h4000_0000;
    endfunction

    function automatic void push(logic [31:0] i, logic w, logic [15:0] p, logic s);
        exp_t e;
        e.ir = i;
        e.rf_we = w;
        e.pc = p;
        sb_q.push_back(e);
        src_q.push_back(s);
    endfunction

    // Memory responder: wait_cycles stall cycles before ready.
    always @(negedge clk) begin
        #1;
        if (force_ready) begin
            imem_ready = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (wcnt >= wait_cycles) begin
                imem_ready = 1'b1;
                imem_rdata = mem_rd(imem_addr);
                wcnt = 0;
            end else begin
                imem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // ALU zero flag per executed instruction, in program order.
    always @(negedge clk) begin
        #1;
        if (!rst && state == 3'd1)
            alu_zero = (zq.size() != 0) ? zq.pop_front() : 1'b0;
    end

    always @(negedge clk) begin
        #2;
        if (!rst && alu_en) begin
            if (src_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL exec_unexpected pc=%h", pc);
            end else begin
                chk("alu_src_imm", alu_src_imm, src_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && retired) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL retire_unexpected pc=%h ir=%h", pc, ir);
            end else begin
                e = sb_q.pop_front();
                chk("retire_ir", ir, e.ir);
                chk("retire_rf_we", rf_we, e.rf_we);
                chk("retire_no_req", imem_req, 32'd0);
                @(negedge clk);
                #2;
                chk("retire_pc", pc, e.pc);
            end
            done_cnt++;
        end
    end

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 400) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (done_cnt < n) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=%0d expected=%0d", done_cnt, n);
        end
    endtask

    initial begin
        int t;
        rst = 1'b1;
        run = 1'b1;
        mem[16'h0000] = 32'h4000_0000;
        mem[16'h0001] = 32'h0000_0004;
        mem[16'h0005] = 32'h2000_3FFE;
        mem[16'h0003] = 32'hC000_0010;
        mem[16'h0004] = 32'h4000_0000;
        mem[16'h0006] = 32'h0000_3FF8;
        mem[16'hFFFE] = 32'h0000_0004;
        mem[16'h0002] = 32'h0000_0005;
        mem[16'h0007] = 32'h0000_0000;
        push(32'h4000_0000, 1'b1, 16'h0001, 1'b0);
        push(32'h0000_0004, 1'b0, 16'h0005, 1'b0);
        push(32'h2000_3FFE, 1'b0, 16'h0003, 1'b0);
        push(32'hC000_0010, 1'b1, 16'h0004, 1'b1);
        push(32'h4000_0000, 1'b1, 16'h0005, 1'b0);
        push(32'h2000_3FFE, 1'b0, 16'h0006, 1'b0);
        push(32'h0000_3FF8, 1'b0, 16'hFFFE, 1'b0);
        push(32'h0000_0004, 1'b0, 16'h0002, 1'b0);
        push(32'h0000_0005, 1'b0, 16'h0007, 1'b0);
        push(32'h0000_0000, 1'b0, 16'h0007, 1'b0);
        zq = '{1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        chk("rst_state", state, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_req", imem_req, 32'd0);
        chk("rst_strobes", {alu_en, alu_src_imm, rf_we, retired, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("c0_state", state, 32'd0);
        chk("c0_req", imem_req, 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        @(negedge clk); #3;
        chk("c1_state", state, 32'd1);
        @(negedge clk); #3;
        chk("c2_state", state, 32'd2);
        chk("c2_alu_en", alu_en, 32'd1);
        @(negedge clk); #3;
        chk("c3_state", state, 32'd3);
        chk("c3_rf_we", rf_we, 32'd1);
        chk("c3_req", imem_req, 32'd0);
        @(negedge clk); #3;
        chk("c4_state", state, 32'd0);
        chk("c4_pc", pc, 32'd1);
        chk("c4_req", imem_req, 32'd1);

        wait_done(10);
`ifdef CPU_CTRL_HALT_DETECT_EN
        for (int k = 0; k < 20; k++) begin
            chk("halt_state", state, 32'd4);
            chk("halt_flag", halted, 32'd1);
            chk("halt_req", imem_req, 32'd0);
            chk("halt_pc", pc, 32'd7);
            @(negedge clk);
            if (k == 19) run = 1'b0;
            #3;
        end
`else
        for (int k = 0; k < 3; k++) push(32'h0, 1'b0, 16'h0007, 1'b0);
        for (int k = 0; k < 12; k++) begin
            chk("loop_req", imem_req, (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("loop_addr", imem_addr, 32'd7);
            chk("loop_halted", halted, 32'd0);
            @(negedge clk);
            if (k == 11) run = 1'b0;
            #3;
        end
`endif
        repeat (3) @(negedge clk);

        mem[16'h0000] = 32'h5000_00AB;
        push(32'h5000_00AB, 1'b1, 16'h0001, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        wait_cycles = 3;
        #3;
        chk("stall_req0", imem_req, 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) run = 1'b0;
            #3;
            chk("stall_req", imem_req, 32'd1);
            chk("stall_addr", imem_addr, 32'd0);
            chk("stall_ir", ir, 32'd0);
        end
        @(negedge clk); #3;
        chk("stall_decode", state, 32'd1);
        chk("stall_ir_load", ir, 32'h5000_00AB);
        wait_done(done_cnt + 1);
        chk("stall_idle_req", imem_req, 32'd0);
        repeat (3) @(negedge clk);

        src_q.push_back(1'b0);
        wait_cycles = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            #3;
            t++;
        end while (state != 3'd2 && t < 20);
        chk("rstx_reached_exec", state, 32'd2);
        rst = 1'b1;
        @(negedge clk); #3;
        chk("rstx_state", state, 32'd0);
        chk("rstx_pc", pc, 32'd0);
        chk("rstx_strobes", {alu_en, rf_we, retired}, 32'd0);
        rst = 1'b0;
        wait_cycles = 10;
        @(negedge clk); #3;
        chk("rstf_req", imem_req, 32'd1);
        @(negedge clk); #3;
        chk("rstf_pending", imem_req, 32'd1);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        force_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rstf_state", state, 32'd0);
        chk("rstf_pc", pc, 32'd0);
        chk("rstf_req_drop", imem_req, 32'd0);
        @(negedge clk); #3;
        chk("stale_state", state, 32'd0);
        chk("stale_ir", ir, 32'd0);
        force_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("src_empty", src_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
